// File: rtl/instr_mem_loadable_if.sv
// Loader + fetch bus for the loadable instruction memory.
//  master : program loader / fetch stage side (drives requests and load words)
//  slave  : the memory itself (drives handshake readies and fetch results)
//  Loader : ld_start, ld_valid, ld_ready, ld_data, ld_last
//  Fetch  : f_req, f_ready, f_addr, f_valid, f_data, f_misalign
//  Status : loaded_words (number of program words currently held)
interface instr_mem_loadable_if #(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 2 ** (WIDTH - 2)
);
  localparam int LWIDTH = $clog2(DEPTH + 1);

  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [DWIDTH-1:0] ld_data;
  logic              ld_last;
  logic              f_req;
  logic              f_ready;
  logic [WIDTH-1:0]  f_addr;
  logic              f_valid;
  logic [DWIDTH-1:0] f_data;
  logic              f_misalign;
  logic [LWIDTH-1:0] loaded_words;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, f_req, f_addr,
    input  ld_ready, f_ready, f_valid, f_data, f_misalign, loaded_words
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, f_req, f_addr,
    output ld_ready, f_ready, f_valid, f_data, f_misalign, loaded_words
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable, synchronous-read instruction memory for the RV32I core.
// A program is streamed in through the loader half of the bus (LOAD state);
// once the last word (or a full array) is accepted the memory serves fetches
// (RUN state) with one-cycle latency. Unloaded or misaligned fetches return NOP.
// Ports:
//  clk  : rising-edge clock
//  rst  : synchronous active-high reset
//  bus  : instr_mem_loadable_if.slave (loader handshake, fetch handshake, loaded_words)
module instr_mem_loadable #(
  parameter int                DWIDTH = 32,
  parameter int                WIDTH  = 8,
  parameter int                DEPTH  = 2 ** (WIDTH - 2),
  parameter logic [DWIDTH-1:0] NOP    = DWIDTH'(32'h00000013)
) (
  input logic                clk,
  input logic                rst,
  instr_mem_loadable_if.slave bus
);
  localparam int IWIDTH = WIDTH - 2;
  localparam int LWIDTH = $clog2(DEPTH + 1);
  localparam int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [LWIDTH-1:0] ptr;
  logic [LWIDTH-1:0] count;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              ld_fire;
  logic              f_fire;
  logic              last_slot;
  logic [IWIDTH-1:0] idx;
  logic              aligned;
  logic              hit;

  assign ld_fire   = bus.ld_valid & bus.ld_ready;
  assign f_fire    = bus.f_req & bus.f_ready;
  assign last_slot = (ptr == LWIDTH'(DEPTH - 1));
  assign idx       = bus.f_addr[WIDTH-1:2];
  assign aligned   = (bus.f_addr[1:0] == 2'b00);
  // count never exceeds DEPTH, so this also rejects indices beyond the array
  assign hit       = aligned && (32'(idx) < 32'(count));

  assign bus.loaded_words = count;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave LOAD on the final word, leave RUN on a reload request
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (ld_fire && (bus.ld_last || last_slot)) state_next = RUN;
      RUN:     if (bus.ld_start) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Handshake outputs: the two ports are never open at the same time
  always_comb begin
    bus.ld_ready = (state == LOAD);
    bus.f_ready  = (state == RUN);
  end

  // Load pointer and loaded word count; a reload request discards the program
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if ((state == RUN) && bus.ld_start) begin
      ptr   <= '0;
      count <= '0;
    end else if (ld_fire) begin
      ptr   <= ptr + 1'b1;
      count <= ptr + 1'b1;
    end
  end

  // Storage array is never cleared; count alone decides which words are valid
  always_ff @(posedge clk) begin
    if (ld_fire && !rst) begin
      mem[ptr[AWIDTH-1:0]] <= bus.ld_data;
    end
  end

  // Registered fetch; results hold between accepted requests
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.f_valid    <= 1'b0;
      bus.f_data     <= NOP;
      bus.f_misalign <= 1'b0;
    end else begin
      bus.f_valid <= f_fire;
      if (f_fire) begin
        bus.f_misalign <= ~aligned;
        bus.f_data     <= hit ? mem[idx[AWIDTH-1:0]] : NOP;
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable.
// A queue-based program model decides which loader words are accepted and what
// each fetch must return; directed steps plus randomized programs and fetches.
module tb_instr_mem_loadable;
  localparam int          DEPTH = 48;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk;
  logic rst;

  instr_mem_loadable_if #(.DWIDTH(32), .WIDTH(8), .DEPTH(DEPTH)) bus ();

  instr_mem_loadable #(.DWIDTH(32), .WIDTH(8), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the loaded program as a queue, plus load/run mode
  logic [31:0] prog[$];
  bit          loading;
  logic [31:0] lastData;

  int checks;
  int passes;

  function automatic logic [31:0] expWord(input logic [7:0] a);
    int i;
    i = int'(a[7:2]);
    if (a[1:0] != 2'b00 || i >= prog.size()) return NOP;
    return prog[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic modelClear();
    prog.delete();
    loading = 1'b1;
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, ".ld_ready"}, 32'(bus.ld_ready), 32'(loading));
    checkOutput({tag, ".f_ready"}, 32'(bus.f_ready), 32'(!loading));
    checkOutput({tag, ".words"}, 32'(bus.loaded_words), 32'(prog.size()));
  endtask

  // Offer one loader word for one cycle
  task automatic applyStimulus(input logic [31:0] d, input bit last, input string tag);
    checkOutput({tag, ".rdy"}, 32'(bus.ld_ready), 32'(loading));
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    if (loading) begin
      prog.push_back(d);
      if (last || prog.size() == DEPTH) loading = 1'b0;
    end
    checkOutput({tag, ".words"}, 32'(bus.loaded_words), 32'(prog.size()));
  endtask

  // Present one fetch request for one cycle and check the registered result
  task automatic fetch(input logic [7:0] a, input string tag);
    bit acc;
    acc = !loading;
    if (acc) lastData = expWord(a);
    bus.f_req  = 1'b1;
    bus.f_addr = a;
    tick();
    bus.f_req = 1'b0;
    checkOutput({tag, ".valid"}, 32'(bus.f_valid), 32'(acc));
    checkOutput({tag, ".data"}, bus.f_data, lastData);
    if (acc) checkOutput({tag, ".mis"}, 32'(bus.f_misalign), 32'(a[1:0] != 2'b00));
  endtask

  task automatic reload();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    if (!loading) modelClear();
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  a;
    int          n;
    checks = 0;
    passes = 0;
    lastData = NOP;
    modelClear();
    rst = 1'b1;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.f_req    = 1'b0;
    bus.f_addr   = '0;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] T1 reset state");
    checkStatus("t1");
    checkOutput("t1.f_valid", 32'(bus.f_valid), 32'd0);
    checkOutput("t1.f_data", bus.f_data, NOP);
    fetch(8'h00, "t1.fetch_in_load");

    $display("[TB] T2 three-word program, back-to-back fetch");
    applyStimulus(32'h00300093, 1'b0, "t2.w0");
    applyStimulus(32'h00900113, 1'b0, "t2.w1");
    applyStimulus(32'h00208133, 1'b1, "t2.w2");
    checkStatus("t2");
    fetch(8'h00, "t2.f0");
    fetch(8'h04, "t2.f4");
    fetch(8'h08, "t2.f8");
    tick();
    checkOutput("t2.idle_valid", 32'(bus.f_valid), 32'd0);
    checkOutput("t2.idle_hold", bus.f_data, lastData);

    $display("[TB] T3 unloaded and misaligned fetch");
    fetch(8'h0C, "t3.unloaded");
    fetch(8'h06, "t3.misalign");
    applyStimulus(32'h12345678, 1'b1, "t3.ld_in_run");
    checkStatus("t3");
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom_range(0, 20));
      fetch(a, "t3.rand");
    end

    $display("[TB] T4 fill whole array");
    reload();
    checkStatus("t4.start");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(32'(i), 1'b0, "t4.fill");
    end
    checkStatus("t4.full");
    applyStimulus(32'hdeadbeef, 1'b0, "t4.extra");
    fetch(8'(4 * (DEPTH - 1)), "t4.lastword");
    fetch(8'(4 * DEPTH), "t4.wrap");
    fetch(8'hFC, "t4.top");

    $display("[TB] T5 reload with simultaneous fetch");
    reload();
    applyStimulus(32'h00300093, 1'b0, "t5.p0");
    applyStimulus(32'h00900113, 1'b0, "t5.p1");
    applyStimulus(32'h00208133, 1'b1, "t5.p2");
    lastData = expWord(8'h00);
    bus.ld_start = 1'b1;
    bus.f_req    = 1'b1;
    bus.f_addr   = 8'h00;
    tick();
    bus.ld_start = 1'b0;
    bus.f_req    = 1'b0;
    modelClear();
    checkOutput("t5.sim_valid", 32'(bus.f_valid), 32'd1);
    checkOutput("t5.sim_data", bus.f_data, 32'h00300093);
    checkStatus("t5.sim");
    fetch(8'h00, "t5.fetch_in_load");
    applyStimulus(32'h0020f1b3, 1'b1, "t5.new");
    fetch(8'h00, "t5.f0");
    fetch(8'h04, "t5.f4");

    $display("[TB] random programs");
    for (int p = 0; p < 4; p++) begin
      reload();
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        d = $urandom;
        applyStimulus(d, i == n - 1, "rnd.load");
      end
      checkStatus("rnd.run");
      for (int i = 0; i < 8; i++) begin
        a = 8'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        fetch(a, "rnd.fetch");
      end
    end

    $display("[TB] reset during fetch");
    bus.f_req  = 1'b1;
    bus.f_addr = 8'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.f_req = 1'b0;
    modelClear();
    lastData = NOP;
    checkOutput("rf.valid", 32'(bus.f_valid), 32'd0);
    checkOutput("rf.data", bus.f_data, NOP);
    checkStatus("rf");

    $display("[TB] T6 reset mid-load");
    applyStimulus(32'h11111111, 1'b0, "t6.a");
    applyStimulus(32'h22222222, 1'b0, "t6.b");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelClear();
    checkStatus("t6.rst");
    applyStimulus(32'h00500293, 1'b1, "t6.one");
    checkStatus("t6.run");
    fetch(8'h00, "t6.f0");
    fetch(8'h04, "t6.f4");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
